// File: rtl/ram_port0_if.sv
// SRAM port0 bus: requester drives select/enable/mask/address/data,
// the responder returns registered read data with a one-cycle valid strobe.
interface ram_port0_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    csb0;
  logic                    web0;
  logic [DATA_WIDTH/8-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [DATA_WIDTH-1:0]   din0;
  logic [DATA_WIDTH-1:0]   dout0;
  logic                    dout_valid0;

  modport master (
    output csb0, web0, wmask0, addr0, din0,
    input  dout0, dout_valid0
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0,
    output dout0, dout_valid0
  );
endinterface

// File: rtl/ram_port0_responder.sv
// Behavioural stand-in for the port0 SRAM macro: byte-masked storage, a
// fixed-latency read pipeline and saturating access/error counters.
module ram_port0_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk0,
  input  logic        rst0_n,
  ram_port0_if.slave  bus,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] err_count
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [RD_LATENCY-1:0] r_vld_p;
  logic [DATA_WIDTH-1:0] r_dat_p [RD_LATENCY];
  logic [15:0]           r_wr_count;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_err_count;

  logic                  w_req;
  logic                  w_rd;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [RD_LATENCY-1:0] w_vld_chain;
  logic [DATA_WIDTH-1:0] w_dat_chain [RD_LATENCY];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_req      = ~bus.csb0;
  assign w_rd       = w_req & bus.web0;
  assign w_in_range = (32'(bus.addr0) < 32'(DEPTH));
  assign w_idx      = bus.addr0[IDX_W-1:0];
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

  // Storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk0) begin
    if (rst0_n && w_req && !bus.web0 && w_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wmask0[i]) r_mem[w_idx][8*i +: 8] <= bus.din0[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_vld_chain    = '0;
    w_vld_chain[0] = w_rd;
    w_dat_chain[0] = w_rd_data;
    for (int k = 1; k < RD_LATENCY; k++) begin
      w_vld_chain[k] = r_vld_p[k-1];
      w_dat_chain[k] = r_dat_p[k-1];
    end
  end

  // Read pipeline: stage k loads only when a valid arrives, so the last
  // stage holds the most recent read data between reads.
  always_ff @(posedge clk0) begin
    for (int k = 0; k < RD_LATENCY; k++) begin
      if (!rst0_n) begin
        r_vld_p[k] <= 1'b0;
        if (k == RD_LATENCY - 1) r_dat_p[k] <= '0;
      end else begin
        r_vld_p[k] <= w_vld_chain[k];
        if (w_vld_chain[k]) r_dat_p[k] <= w_dat_chain[k];
      end
    end
  end

  // Out-of-range accesses count only as errors, never as reads or writes.
  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_count <= '0;
    end else if (w_req) begin
      if (!w_in_range)    r_err_count <= sat_inc(r_err_count);
      else if (!bus.web0) r_wr_count  <= sat_inc(r_wr_count);
      else                r_rd_count  <= sat_inc(r_rd_count);
    end
  end

  assign bus.dout0       = r_dat_p[RD_LATENCY-1];
  assign bus.dout_valid0 = r_vld_p[RD_LATENCY-1];
  assign wr_count        = r_wr_count;
  assign rd_count        = r_rd_count;
  assign err_count       = r_err_count;
endmodule

// File: tb/tb_ram_port0_responder.sv
// Drives four responders (latency 1..4, the latency-3 one with DEPTH=200)
// with one shared request stream and checks each against a transaction model.
module tb_ram_port0_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        csb;
  logic        web;
  logic [3:0]  wmask;
  logic [7:0]  addr;
  logic [31:0] din;

  logic [3:0][31:0] dout_a;
  logic [3:0]       vld_a;
  logic [3:0][15:0] wr_a;
  logic [3:0][15:0] rd_a;
  logic [3:0][15:0] err_a;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_port0_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_if ();
    assign bus_if.csb0   = csb;
    assign bus_if.web0   = web;
    assign bus_if.wmask0 = wmask;
    assign bus_if.addr0  = addr;
    assign bus_if.din0   = din;
    assign dout_a[g]     = bus_if.dout0;
    assign vld_a[g]      = bus_if.dout_valid0;

    ram_port0_responder #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(8),
      .DEPTH     ((g == 2) ? 200 : 256),
      .RD_LATENCY(g + 1)
    ) u_dut (
      .clk0     (clk),
      .rst0_n   (rst_n),
      .bus      (bus_if),
      .wr_count (wr_a[g]),
      .rd_count (rd_a[g]),
      .err_count(err_a[g])
    );
  end

  typedef struct {
    int          k;
    int          due;
    logic [31:0] d;
  } pend_t;

  logic [31:0] mmem [4][256];
  int          mwr [4];
  int          mrd [4];
  int          merr [4];
  logic [31:0] mdout [4];
  logic        mvld [4];
  pend_t       pq [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // Transaction-level model: each read becomes a pending result due a fixed
  // number of edges later; reset simply forgets everything outstanding.
  task automatic model_update();
    pend_t p;
    pend_t keep [$];
    int    lat;
    int    dep;
    cyc++;
    if (!rst_n) begin
      pq.delete();
      for (int k = 0; k < 4; k++) begin
        mdout[k] = 32'h0; mvld[k] = 1'b0;
        mwr[k] = 0; mrd[k] = 0; merr[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 4; k++) begin
      mvld[k] = 1'b0;
      if (!csb) begin
        lat = k + 1;
        dep = (k == 2) ? 200 : 256;
        p.k = k;
        p.due = cyc + lat - 1;
        if (int'(addr) >= dep) begin
          merr[k] = sat16(merr[k]);
          if (web) begin p.d = 32'h0; pq.push_back(p); end
        end else if (!web) begin
          for (int b = 0; b < 4; b++)
            if (wmask[b]) mmem[k][addr][8*b +: 8] = din[8*b +: 8];
          mwr[k] = sat16(mwr[k]);
        end else begin
          p.d = mmem[k][addr];
          pq.push_back(p);
          mrd[k] = sat16(mrd[k]);
        end
      end
    end
    foreach (pq[i]) begin
      if (pq[i].due == cyc) begin
        mdout[pq[i].k] = pq[i].d;
        mvld[pq[i].k]  = 1'b1;
      end else begin
        keep.push_back(pq[i]);
      end
    end
    pq = keep;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk("dout0", k, dout_a[k], mdout[k]);
      chk("dout_valid0", k, 32'(vld_a[k]), 32'(mvld[k]));
      chk("wr_count", k, 32'(wr_a[k]), 32'(mwr[k]));
      chk("rd_count", k, 32'(rd_a[k]), 32'(mrd[k]));
      chk("err_count", k, 32'(err_a[k]), 32'(merr[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    csb = 1'b1; web = 1'b1;
    repeat (n) tick();
  endtask

  task automatic op_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb = 1'b0; web = 1'b0; addr = a; din = d; wmask = m;
    tick();
    csb = 1'b1; web = 1'b1;
  endtask

  task automatic op_rd(input logic [7:0] a);
    csb = 1'b0; web = 1'b1; addr = a; din = 32'h0; wmask = 4'h0;
    tick();
    csb = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; csb = 1'b1; web = 1'b1; wmask = 4'h0; addr = 8'h0; din = 32'h0;
    @(negedge clk);
    idle(3);
    chk("lit_rst_dout", 1, dout_a[1], 32'h0);
    chk("lit_rst_vld", 1, 32'(vld_a[1]), 32'h0);
    chk("lit_rst_cnt", 1, 32'(wr_a[1] | rd_a[1] | err_a[1]), 32'h0);
    rst_n = 1'b1;

    op_wr(8'h10, 32'hDEADBEEF, 4'hF);
    op_rd(8'h10);
    chk("lit_lat1_dout", 0, dout_a[0], 32'hDEADBEEF);
    chk("lit_lat2_early_vld", 1, 32'(vld_a[1]), 32'h0);
    idle(1);
    chk("lit_lat2_dout", 1, dout_a[1], 32'hDEADBEEF);
    chk("lit_lat2_vld", 1, 32'(vld_a[1]), 32'h1);
    chk("lit_wr1", 1, 32'(wr_a[1]), 32'h1);
    chk("lit_rd1", 1, 32'(rd_a[1]), 32'h1);

    op_wr(8'h05, 32'h11223344, 4'hF);
    op_wr(8'h05, 32'hAABBCCDD, 4'b0101);
    op_rd(8'h05);
    idle(4);
    chk("lit_mask_dout", 3, dout_a[3], 32'h11BB33DD);
    op_wr(8'h05, 32'hFFFFFFFF, 4'h0);
    op_rd(8'h05);
    idle(4);
    chk("lit_mask0_dout", 0, dout_a[0], 32'h11BB33DD);
    chk("lit_mask0_wr", 0, 32'(wr_a[0]), 32'd4);

    for (int i = 0; i < 4; i++) op_wr(8'(i), 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) op_rd(8'(i));
    chk("lit_stream_lat4", 3, dout_a[3], 32'hA0);
    chk("lit_stream_lat1", 0, dout_a[0], 32'hA3);
    idle(4);
    op_wr(8'h07, 32'h77, 4'hF);
    op_rd(8'h07);
    chk("lit_wr_then_rd", 0, dout_a[0], 32'h77);
    idle(4);

    op_wr(8'h09, 32'h1, 4'hF);
    op_rd(8'h09);
    op_wr(8'h09, 32'h2, 4'hF);
    idle(1);
    chk("lit_snapshot", 2, dout_a[2], 32'h1);
    chk("lit_snapshot_vld", 2, 32'(vld_a[2]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("lit_hold_dout", 2, dout_a[2], 32'h1);
      chk("lit_hold_vld", 2, 32'(vld_a[2]), 32'h0);
    end

    op_wr(8'd250, 32'hCAFEF00D, 4'hF);
    op_rd(8'd250);
    idle(2);
    chk("lit_oor_dout", 2, dout_a[2], 32'h0);
    chk("lit_oor_vld", 2, 32'(vld_a[2]), 32'h1);
    chk("lit_oor_err", 2, 32'(err_a[2]), 32'd2);
    chk("lit_oor_wr", 2, 32'(wr_a[2]), 32'd11);
    chk("lit_oor_rd", 2, 32'(rd_a[2]), 32'd9);
    chk("lit_inrange_250", 1, dout_a[1], 32'hCAFEF00D);

    op_wr(8'h20, 32'h5A5A1234, 4'hF);
    op_rd(8'h20);
    idle(1);
    rst_n = 1'b0;
    op_rd(8'h20);
    chk("lit_midrst_vld", 3, 32'(vld_a[3]), 32'h0);
    chk("lit_midrst_dout", 3, dout_a[3], 32'h0);
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("lit_postrst_vld", 3, 32'(vld_a[3]), 32'h0);
    end
    op_rd(8'h20);
    idle(3);
    chk("lit_persist_dout", 3, dout_a[3], 32'h5A5A1234);
    chk("lit_persist_vld", 3, 32'(vld_a[3]), 32'h1);
    chk("lit_persist_rd", 3, 32'(rd_a[3]), 32'd1);

    for (int i = 0; i < 65537; i++) op_rd(8'h20);
    idle(4);
    chk("lit_rd_sat", 1, 32'(rd_a[1]), 32'hFFFF);
    chk("lit_rd_sat", 0, 32'(rd_a[0]), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
